// File: rtl/uart_alici_pkg.sv
// Shared UART constants.
// The transmitter and the receiver both import this package so they agree on
// line levels, frame width and the receive FSM state encoding.
//   HIGH / LOW      : idle / active line levels
//   UART_VERI_BIT   : data bits per frame (8N1)
//   alici_durum_e   : receive FSM states (BOSTA, BASLA, VERI_AL, BITIR)
package uart_alici_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int UART_VERI_BIT = 8;

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,  // idle, waiting for a falling edge on the line
    BASLA   = 2'd1,  // start bit, waiting for its middle
    VERI_AL = 2'd2,  // data bits, one sample per bit period
    BITIR   = 2'd3   // stop bit
  } alici_durum_e;

endpackage

// File: rtl/uart_alici_senkronizor.sv
// senkronizor: two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_DEGERI so the output matches the input's idle
// level straight out of reset.
//   clk_i  : destination clock
//   rstn_i : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk_i cycles of latency)
module senkronizor #(
  parameter logic RESET_DEGERI = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic ff1_r;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ff1_r <= RESET_DEGERI;
      q_o   <= RESET_DEGERI;
    end else begin
      ff1_r <= d_i;
      q_o   <= ff1_r;
    end
  end

endmodule

// File: rtl/uart_alici.sv
// uart_alici: 8N1 UART receiver, LSB first, mid-bit sampling.
// Bit period P = baud_r + 1 cycles; baud_div_i is captured on the start edge
// so reprogramming it mid-frame only affects the next frame.
//   clk_i            : clock
//   rstn_i           : asynchronous active-low reset
//   rx_i             : serial line, asynchronous, idles high
//   baud_div_i       : bit period minus one (>= 3)
//   fifo_dolu_i      : RX FIFO full, looked at only in the stop-sample cycle
//   veri_o           : last successfully received byte
//   veri_gecerli_o   : one-cycle FIFO write pulse, veri_o valid with it
//   cerceve_hatasi_o : one-cycle pulse, stop bit sampled low
//   tasma_o          : one-cycle pulse, byte dropped because FIFO full
//   mesgul_o         : high while not in BOSTA
//   durum_o          : current FSM state, for observation
// Output handshake: veri_gecerli_o is a push-only strobe with no ready; the
// FIFO must accept it in the same cycle, otherwise tasma_o fires instead.
module uart_alici
  import uart_alici_pkg::*;
(
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         rx_i,
  input  logic [15:0]  baud_div_i,
  input  logic         fifo_dolu_i,
  output logic [7:0]   veri_o,
  output logic         veri_gecerli_o,
  output logic         cerceve_hatasi_o,
  output logic         tasma_o,
  output logic         mesgul_o,
  output alici_durum_e durum_o
);

  localparam logic [2:0] SON_BIT = 3'(UART_VERI_BIT - 1);

  alici_durum_e durum_r;
  logic         rx_s;
  logic         rx_s_q;
  logic         baslangic_kenari;
  logic [15:0]  baud_r;
  logic [15:0]  yarim;
  logic [15:0]  sayac_r;
  logic [2:0]   bit_r;
  logic [7:0]   kaydirma_r;

  senkronizor #(
    .RESET_DEGERI (HIGH)
  ) u_rx_senk (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // Third flop for edge detection; resets high so a line that is already low
  // when reset releases never looks like a start edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rx_s_q <= HIGH;
    else         rx_s_q <= rx_s;
  end

  assign baslangic_kenari = (rx_s_q == HIGH) && (rx_s == LOW);
  assign yarim            = baud_r >> 1;
  assign mesgul_o         = (durum_r != BOSTA);
  assign durum_o          = durum_r;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_r          <= BOSTA;
      baud_r           <= '0;
      sayac_r          <= '0;
      bit_r            <= '0;
      kaydirma_r       <= '0;
      veri_o           <= '0;
      veri_gecerli_o   <= LOW;
      cerceve_hatasi_o <= LOW;
      tasma_o          <= LOW;
    end else begin
      veri_gecerli_o   <= LOW;
      cerceve_hatasi_o <= LOW;
      tasma_o          <= LOW;
      case (durum_r)
        BOSTA: begin
          if (baslangic_kenari) begin
            sayac_r <= '0;
            baud_r  <= baud_div_i;
            durum_r <= BASLA;
          end
        end
        BASLA: begin
          if (sayac_r == yarim) begin
            // Line back high at mid-start means a glitch: drop silently.
            if (rx_s == LOW) begin
              sayac_r <= '0;
              bit_r   <= '0;
              durum_r <= VERI_AL;
            end else begin
              durum_r <= BOSTA;
            end
          end else begin
            sayac_r <= sayac_r + 16'd1;
          end
        end
        VERI_AL: begin
          if (sayac_r == baud_r) begin
            kaydirma_r <= {rx_s, kaydirma_r[7:1]};
            sayac_r    <= '0;
            bit_r      <= bit_r + 3'd1;
            if (bit_r == SON_BIT) durum_r <= BITIR;
          end else begin
            sayac_r <= sayac_r + 16'd1;
          end
        end
        BITIR: begin
          // Leave at mid-stop so a following start edge is never missed.
          if (sayac_r == baud_r) begin
            durum_r <= BOSTA;
            if (rx_s == HIGH) begin
              if (fifo_dolu_i == LOW) begin
                veri_o         <= kaydirma_r;
                veri_gecerli_o <= HIGH;
              end else begin
                tasma_o <= HIGH;
              end
            end else begin
              cerceve_hatasi_o <= HIGH;
            end
          end else begin
            sayac_r <= sayac_r + 16'd1;
          end
        end
        default: durum_r <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alici.sv
// Bench for uart_alici: directed frames from the test plan plus randomized
// frames, checked against a frame-level model of the receiver.
module tb_uart_alici;
  import uart_alici_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         rx_i = 1'b1;
  logic [15:0]  baud_div_i = 16'd15;
  logic         fifo_dolu_i = 1'b0;
  logic [7:0]   veri_o;
  logic         veri_gecerli_o;
  logic         cerceve_hatasi_o;
  logic         tasma_o;
  logic         mesgul_o;
  alici_durum_e durum_o;

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  uart_alici dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .rx_i             (rx_i),
    .baud_div_i       (baud_div_i),
    .fifo_dolu_i      (fifo_dolu_i),
    .veri_o           (veri_o),
    .veri_gecerli_o   (veri_gecerli_o),
    .cerceve_hatasi_o (cerceve_hatasi_o),
    .tasma_o          (tasma_o),
    .mesgul_o         (mesgul_o),
    .durum_o          (durum_o)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic kontrol(input string tag, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_chk++;
    if (gozlenen === beklenen) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, gozlenen, beklenen, cyc);
  endtask

  // ---------------- scoreboard ----------------
  // Event entry: {cycle[31:0], kind[2:0] one-hot {frame_err, overrun, valid}, veri_o[7:0]}
  localparam logic [2:0] K_GECERLI = 3'b001;
  localparam logic [2:0] K_TASMA   = 3'b010;
  localparam logic [2:0] K_CERCEVE = 3'b100;
  logic [42:0] exp_q[$];
  logic [31:0] busy_q[$];
  logic [7:0]  son_iyi = 8'h00;  // model of veri_o

  // Frame-level model: a frame whose falling edge is driven at cycle c0 (at a
  // negedge) is sampled mid-stop; the status pulse is visible from cycle
  // c0 + 4 + H + 9P (3 sync/edge cycles, H to mid-start, 9 periods, 1 register).
  // mesgul_o stays high H + 9P + 1 cycles.
  task automatic model_cerceve(input int unsigned c0, input logic [7:0] d, input int div,
                               input logic stop_v, input logic dolu);
    int p;
    int h;
    logic [31:0] t;
    p = div + 1;
    h = div / 2;
    t = 32'(c0 + 4 + h + 9 * p);
    if (!stop_v)  exp_q.push_back({t, K_CERCEVE, son_iyi});
    else if (dolu) exp_q.push_back({t, K_TASMA, son_iyi});
    else begin
      son_iyi = d;
      exp_q.push_back({t, K_GECERLI, d});
    end
    busy_q.push_back(32'(h + 9 * p + 1));
  endtask

  // ---------------- monitor ----------------
  int unsigned busy_len = 0;
  logic [2:0]  m_tur;
  logic [42:0] m_e;
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (veri_gecerli_o || tasma_o || cerceve_hatasi_o) begin
        m_tur = {cerceve_hatasi_o, tasma_o, veri_gecerli_o};
        if (exp_q.size() == 0) begin
          kontrol("beklenmeyen_darbe", {29'd0, m_tur}, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          kontrol("darbe_zamani", cyc, m_e[42:11]);
          kontrol("darbe_turu", {29'd0, m_tur}, {29'd0, m_e[10:8]});
          kontrol("veri_o", {24'd0, veri_o}, {24'd0, m_e[7:0]});
        end
      end
      if (mesgul_o) begin
        busy_len++;
      end else if (busy_len != 0) begin
        if (busy_q.size() == 0) kontrol("beklenmeyen_mesgul", busy_len, 32'd0);
        else                    kontrol("mesgul_suresi", busy_len, busy_q.pop_front());
        busy_len = 0;
      end
    end else begin
      busy_len = 0;
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end on a negedge. send_frame leaves the stop level
  // on the line so frames can be chained with zero idle time.
  // rst_b >= 0: assert reset in the middle of line slot rst_b, release three
  // slots later; the frame then produces no events.
  task automatic send_frame(input logic [7:0] d, input int div, input logic stop_v,
                            input logic dolu, input bit baud_degis, input int rst_b);
    int p;
    int unsigned c0;
    logic [9:0] bitler;
    p = div + 1;
    bitler = {stop_v, d, 1'b0};
    baud_div_i  = 16'(div);
    fifo_dolu_i = dolu;
    c0 = cyc;
    if (rst_b < 0) model_cerceve(c0, d, div, stop_v, dolu);
    for (int b = 0; b < 10; b++) begin
      rx_i = bitler[b];
      for (int k = 0; k < p; k++) begin
        if (baud_degis && b == 0 && k == 5) baud_div_i = 16'($urandom_range(3, 40));
        if (b == rst_b && k == p / 2) begin
          #2 rstn_i = 1'b0;
          son_iyi = 8'h00;
          #1;
          kontrol("rst_veri_o", {24'd0, veri_o}, 32'd0);
          kontrol("rst_darbeler", {29'd0, veri_gecerli_o, tasma_o, cerceve_hatasi_o}, 32'd0);
          kontrol("rst_mesgul", {31'd0, mesgul_o}, 32'd0);
        end
        if (b == rst_b + 3 && k == p / 2) rstn_i = 1'b1;
        @(negedge clk_i);
      end
    end
  endtask

  task automatic bekle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int div;
    logic stop_v;
    logic [7:0] d;
    int unsigned bas;

    repeat (3) @(negedge clk_i);
    kontrol("reset_veri_o", {24'd0, veri_o}, 32'd0);
    kontrol("reset_mesgul", {31'd0, mesgul_o}, 32'd0);
    kontrol("reset_durum", {30'd0, durum_o}, {30'd0, BOSTA});
    rstn_i = 1'b1;
    bekle(10);
    kontrol("bosta_sonrasi_reset", {30'd0, durum_o}, {30'd0, BOSTA});

    // 0x55 at P=16: pulse 4+7+144 cycles after the drive cycle.
    send_frame(8'h55, 15, 1'b1, 1'b0, 1'b0, -1);
    bekle(20);

    // 4-cycle low glitch: busy for H+1 = 8 cycles, no pulses.
    baud_div_i = 16'd15;
    busy_q.push_back(32'd8);
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    bekle(40);

    // Framing error, then BREAK for 40 more cycles: exactly one pulse.
    send_frame(8'hA3, 15, 1'b0, 1'b0, 1'b0, -1);
    repeat (40) @(negedge clk_i);
    kontrol("break_bosta", {30'd0, durum_o}, {30'd0, BOSTA});
    bekle(20);

    // Overrun, then a normal byte.
    send_frame(8'h3C, 15, 1'b1, 1'b1, 1'b0, -1);
    bekle(5);
    send_frame(8'hC3, 15, 1'b1, 1'b0, 1'b0, -1);
    bekle(10);

    // Back-to-back at P=8, no idle between frames: pulses 80 cycles apart.
    send_frame(8'h00, 7, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'hFF, 7, 1'b1, 1'b0, 1'b0, -1);
    bekle(10);

    // Reset during data bit 4 of 0x96 (line slot 5), released during bit 7.
    send_frame(8'h96, 15, 1'b1, 1'b0, 1'b0, 5);
    bekle(10);
    send_frame(8'h12, 15, 1'b1, 1'b0, 1'b0, -1);
    bekle(10);

    // Randomized frames: baud, data, stop errors, FIFO full, mid-frame baud writes.
    for (int n = 0; n < 24; n++) begin
      div    = $urandom_range(3, 20);
      d      = 8'($urandom);
      stop_v = ($urandom_range(0, 7) != 0);
      send_frame(d, div, stop_v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), -1);
      if (!stop_v || $urandom_range(0, 1) == 1) bekle($urandom_range(1, 6));
    end
    bekle(5);

    // Drain: bounded wait for every expected event.
    bas = cyc;
    while ((exp_q.size() != 0 || busy_q.size() != 0) && (cyc - bas) < 2000)
      @(negedge clk_i);
    kontrol("bekleyen_olay", exp_q.size(), 32'd0);
    kontrol("bekleyen_mesgul", busy_q.size(), 32'd0);
    kontrol("son_veri_o", {24'd0, veri_o}, {24'd0, son_iyi});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
